// File: rtl/spi_regfile.sv
// spi_regfile: SPI mode-0 peripheral register file, fully oversampled in the clk domain.
module spi_regfile #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         SCLK,
  input  logic                         COPI,
  input  logic                         nCS,
  output logic                         CIPO,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_stb,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err,
  output logic                         busy
);
  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME_W + 2);
  logic [2:0] r_sclk, r_ncs;
  logic [1:0] r_copi;
  logic r_live, r_hi_seen, r_armed, r_rd_act, r_wr_stb, r_frame_err;
  logic [CNT_W-1:0] r_cnt;
  logic [FRAME_W-1:0] r_shift;
  logic [DATA_W-1:0] r_rd;
  logic [NUM_REGS*DATA_W-1:0] r_regs;
  logic [ADDR_W-1:0] r_wr_addr;
  logic w_sclk_rise, w_sclk_fall, w_ncs_rise, w_ncs_fall;
  logic w_full, w_addr_ok, w_commit, w_err, w_load;
  logic [FRAME_W-1:0] w_shift_nx;
  logic [ADDR_W-1:0] w_addr, w_rd_addr;
  logic [DATA_W-1:0] w_data, w_rd_val;
  assign w_sclk_rise = r_sclk[1] & ~r_sclk[2];
  assign w_sclk_fall = ~r_sclk[1] & r_sclk[2];
  assign w_ncs_rise = r_ncs[1] & ~r_ncs[2];
  assign w_ncs_fall = ~r_ncs[1] & r_ncs[2];
  assign w_shift_nx = {r_shift[FRAME_W-2:0], r_copi[1]};
  assign w_addr = r_shift[DATA_W +: ADDR_W];
  assign w_data = r_shift[DATA_W-1:0];
  assign w_rd_addr = w_shift_nx[ADDR_W-1:0];
  assign w_full = r_cnt == CNT_W'(FRAME_W);
  assign w_addr_ok = {1'b0, w_addr} < (ADDR_W+1)'(NUM_REGS);
  assign w_commit = w_full & r_shift[FRAME_W-1] & w_addr_ok;
  assign w_err = ~w_full | (r_shift[FRAME_W-1] & ~w_addr_ok);
  assign w_load = w_sclk_rise & (r_cnt == CNT_W'(ADDR_W)) & ~w_shift_nx[ADDR_W];
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (w_rd_addr == ADDR_W'(i)) w_rd_val = r_regs[i*DATA_W +: DATA_W];
  end
  // r_hi_seen blocks arming until nCS has been genuinely sampled high after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk <= '0;
      r_copi <= '0;
      r_ncs <= '1;
      r_live <= 1'b0;
      r_hi_seen <= 1'b0;
    end else begin
      r_sclk <= {r_sclk[1:0], SCLK};
      r_copi <= {r_copi[0], COPI};
      r_ncs <= {r_ncs[1:0], nCS};
      r_live <= 1'b1;
      r_hi_seen <= r_hi_seen | (r_live & r_ncs[0]);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
      r_rd_act <= 1'b0;
      r_cnt <= '0;
      r_shift <= '0;
      r_rd <= '0;
      r_wr_addr <= '0;
      r_wr_stb <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_stb <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_ncs_rise) begin
        if (r_armed) begin
          if (w_commit) r_wr_addr <= w_addr;
          r_wr_stb <= w_commit;
          r_frame_err <= w_err;
        end
        r_armed <= 1'b0;
        r_rd_act <= 1'b0;
      end else if (w_ncs_fall) begin
        r_armed <= r_hi_seen;
        r_cnt <= '0;
        r_shift <= '0;
        r_rd_act <= 1'b0;
      end else if (r_armed & w_sclk_rise) begin
        r_shift <= w_shift_nx;
        if (r_cnt != CNT_W'(FRAME_W + 1)) r_cnt <= r_cnt + 1'b1;
        if (w_load) begin
          r_rd <= w_rd_val;
          r_rd_act <= 1'b1;
        end
      end else if (r_armed & w_sclk_fall & r_rd_act & (r_cnt > CNT_W'(1 + ADDR_W))) begin
        r_rd <= r_rd << 1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_regs <= '0;
    else
      for (int i = 0; i < NUM_REGS; i++)
        if (w_ncs_rise & r_armed & w_commit & (w_addr == ADDR_W'(i)))
          r_regs[i*DATA_W +: DATA_W] <= w_data;
  end
  assign CIPO = r_rd_act & r_rd[DATA_W-1];
  assign regs_flat = r_regs;
  assign wr_stb = r_wr_stb;
  assign wr_addr = r_wr_addr;
  assign frame_err = r_frame_err;
  assign busy = r_armed;
endmodule

// File: tb/tb_spi_regfile.sv
// tb_spi_regfile: scoreboard bench for spi_regfile (default and 16x16 configurations).
module tb_spi_regfile;
  logic clk = 0, rst_n = 0, SCLK = 0, COPI = 0, ncs0 = 1, ncs1 = 1;
  logic cipo0, stb0, err0, busy0, cipo1, stb1, err1, busy1;
  logic [39:0] rf0;
  logic [255:0] rf1;
  logic [6:0] wa0;
  logic [3:0] wa1;
  int n_vec = 0, n_bad = 0;
  typedef struct {
    logic err;
    logic [6:0] addr;
    logic [255:0] regs;
  } ev_t;
  ev_t q0[$], q1[$];
  logic [255:0] rq[$];
  logic [255:0] m[2];
  logic [6:0] last[2];
  always #5 clk = ~clk;
  spi_regfile dut0 (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .COPI(COPI), .nCS(ncs0), .CIPO(cipo0),
    .regs_flat(rf0), .wr_stb(stb0), .wr_addr(wa0), .frame_err(err0), .busy(busy0)
  );
  spi_regfile #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .COPI(COPI), .nCS(ncs1), .CIPO(cipo1),
    .regs_flat(rf1), .wr_stb(stb1), .wr_addr(wa1), .frame_err(err1), .busy(busy1)
  );
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (stb0 | err0) begin
    ev_t e;
    if (q0.size() == 0) check("dut0 spurious pulse", {stb0, err0}, 0);
    else begin
      e = q0.pop_front();
      check("dut0 pulse kind", {stb0, err0}, e.err ? 2'b01 : 2'b10);
      check("dut0 wr_addr", wa0, e.addr);
      check("dut0 regs", rf0, e.regs);
    end
  end
  always @(negedge clk) if (stb1 | err1) begin
    ev_t e;
    if (q1.size() == 0) check("dut1 spurious pulse", {stb1, err1}, 0);
    else begin
      e = q1.pop_front();
      check("dut1 pulse kind", {stb1, err1}, e.err ? 2'b01 : 2'b10);
      check("dut1 wr_addr", wa1, e.addr);
      check("dut1 regs", rf1, e.regs);
    end
  end
  task automatic send(input int d, input int n, input logic [31:0] b, input int rst_at = -1);
    int fw, aw, dw, nr, addr;
    logic rw, rd;
    logic [15:0] dat;
    logic [255:0] rd_got, v;
    ev_t e;
    fw = d ? 21 : 16;
    aw = d ? 4 : 7;
    dw = d ? 16 : 8;
    nr = d ? 16 : 5;
    rw = b[n-1];
    addr = int'((b >> dw) & ((32'd1 << aw) - 1));
    dat = 16'(b & ((32'd1 << dw) - 1));
    rd = (rst_at < 0) && (n == fw) && !rw;
    rd_got = '0;
    if (rst_at < 0) begin
      if (n != fw || (rw && addr >= nr)) begin
        e.err = 1; e.addr = last[d]; e.regs = m[d];
        if (d) q1.push_back(e); else q0.push_back(e);
      end else if (rw) begin
        for (int k = 0; k < dw; k++) m[d][addr*dw+k] = dat[k];
        last[d] = 7'(addr);
        e.err = 0; e.addr = last[d]; e.regs = m[d];
        if (d) q1.push_back(e); else q0.push_back(e);
      end else begin
        v = '0;
        if (addr < nr) for (int k = 0; k < dw; k++) v[k] = m[d][addr*dw+k];
        rq.push_back(v);
      end
    end
    @(posedge clk) #1;
    if (d) ncs1 = 0; else ncs0 = 0;
    repeat (5) @(posedge clk);
    for (int j = 0; j < n; j++) begin
      if (j == rst_at) begin
        #7 rst_n = 0;
        #3;
        check("reset busy", d ? busy1 : busy0, 0);
        check("reset regs", d ? rf1 : 256'(rf0), 0);
        check("reset wr_addr", d ? 7'(wa1) : wa0, 0);
        check("reset cipo", d ? cipo1 : cipo0, 0);
        m[0] = '0; m[1] = '0; last[0] = '0; last[1] = '0;
        #20 rst_n = 1;
      end
      COPI = b[n-1-j];
      #50;
      if (rd && j > aw && j <= aw + dw) rd_got = {rd_got[254:0], d ? cipo1 : cipo0};
      SCLK = 1;
      #50 SCLK = 0;
    end
    COPI = 0;
    #50;
    if (rd) check("read data", rd_got, rq.pop_front());
    @(posedge clk) #1;
    check("busy in frame", d ? busy1 : busy0, rst_at < 0);
    if (d) ncs1 = 1; else ncs0 = 1;
    @(posedge clk);
    @(posedge clk) #1;
    check("busy at k+1", d ? busy1 : busy0, rst_at < 0);
    @(posedge clk) #1;
    check("busy at k+2", d ? busy1 : busy0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("pending events", d ? q1.size() : q0.size(), 0);
    check("cipo idle", d ? cipo1 : cipo0, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int a, dv;
    m[0] = '0; m[1] = '0; last[0] = '0; last[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst regs0", rf0, 0);
    check("rst regs1", rf1, 0);
    check("rst wr_addr", wa0, 0);
    check("rst busy", busy0, 0);
    check("rst cipo", cipo0, 0);
    check("rst pulses", {stb0, err0, stb1, err1}, 0);
    rst_n = 1;
    repeat (4) @(posedge clk);
    send(0, 16, 32'h82AA);
    check("addr2 byte", rf0[23:16], 8'hAA);
    check("other regs zero", {rf0[39:24], rf0[15:0]}, 0);
    send(0, 16, 32'h0255);
    send(0, 16, 32'h8577);
    send(0, 16, 32'h0900);
    send(0, 15, 32'h4155);
    send(0, 17, 32'h10555);
    send(0, 16, 32'h8133, 6);
    check("regs after mid-frame reset", rf0, 0);
    send(0, 16, 32'h803C);
    repeat (6) begin
      a = $urandom_range(0, 6);
      dv = $urandom_range(0, 255);
      send(0, 16, 32'({1'b1, 7'(a), 8'(dv)}));
      a = $urandom_range(0, 7);
      send(0, 16, 32'({1'b0, 7'(a), 8'h5A}));
    end
    send(1, 21, 32'h1FBEEF);
    check("dut1 reg15", rf1[255:240], 16'hBEEF);
    check("dut1 others zero", rf1[239:0], 0);
    send(1, 21, 32'h0F0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_regfile.md
SPI_REGFILE -- requirements
Module: spi_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 5, number of DATA_W-bit registers (1..2**ADDR_W).
REQ-002 SHALL have parameter ADDR_W, default 7, address field width in the frame.
REQ-003 SHALL have parameter DATA_W, default 8, data field width; FRAME_W = 1+ADDR_W+DATA_W (default 16).
REQ-004 SHALL have port clk input 1, single system clock; all logic rising-edge on clk.
REQ-005 SHALL have port rst_n input 1, asynchronous active-low reset.
REQ-006 SHALL have port SCLK input 1, SPI clock, asynchronous to clk, mode 0.
REQ-007 SHALL have port COPI input 1, serial data from controller, MSB first.
REQ-008 SHALL have port nCS input 1, active-low frame select.
REQ-009 SHALL have port CIPO output 1, serial read data to controller.
REQ-010 SHALL have port regs_flat output NUM_REGS*DATA_W, register i at bits [i*DATA_W +: DATA_W].
REQ-011 SHALL have port wr_stb output 1, one-cycle pulse on committed write.
REQ-012 SHALL have port wr_addr output ADDR_W, address of last committed write, held until next commit.
REQ-013 SHALL have port frame_err output 1, one-cycle pulse on rejected frame.
REQ-014 SHALL have port busy output 1, high while synchronized nCS low and frame armed.

Function
REQ-015 SHALL synchronize SCLK, COPI, nCS through two flops into clk, plus a third stage for edge detect; no logic clocked by SCLK or nCS.
REQ-016 SHALL require clk >= 8x SCLK; behaviour below that is undefined.
REQ-017 SHALL arm a frame on synchronized nCS fall: bit counter <= 0, shift register cleared, busy <= 1.
REQ-018 SHALL, per synchronized SCLK rise while armed, shift synchronized COPI into shift register LSB and increment counter, saturating at FRAME_W+1.
REQ-019 SHALL decode frame bit 0 (first received) as R/W (1 = write), next ADDR_W bits as address, last DATA_W bits as data.
REQ-020 SHALL, on the SCLK rise making counter = 1+ADDR_W with R/W = 0, load read shift register with register[addr], or all zeros if addr >= NUM_REGS.
REQ-021 SHALL drive CIPO = read shift register MSB during a read data phase, shift left on each synchronized SCLK fall thereafter, CIPO = 0 otherwise.
REQ-022 SHALL commit on synchronized nCS rise: counter = FRAME_W, write, addr < NUM_REGS -> register[addr] <= data, wr_addr <= addr, wr_stb = 1.
REQ-023 SHALL, on nCS rise with counter != FRAME_W, or write with addr >= NUM_REGS, leave registers and wr_addr unchanged and pulse frame_err.
REQ-024 SHALL treat a well-formed read frame as no-commit: no wr_stb, no frame_err, registers unchanged.
REQ-025 SHALL, with nCS pin high sampled at clk edge k, update registers/wr_stb/frame_err/busy at edge k+2 (fixed latency).
REQ-026 SHALL ignore SCLK edges while not armed; nCS glitch shorter than 2 clk may be missed without corrupting state.
REQ-027 SHALL give nCS rise and a coincident SCLK edge priority to nCS rise; the SCLK edge is discarded.

Reset
REQ-028 SHALL, on rst_n low, immediately clear registers to 0, wr_addr to 0, wr_stb/frame_err/busy/CIPO to 0, counter to 0, disarm.
REQ-029 SHALL initialize synchronizer nCS stages to 1 and SCLK stages to 0 so reset release never fakes an edge.
REQ-030 SHALL, if reset releases with nCS low, stay disarmed until a fresh nCS fall; the partial frame produces no commit and no frame_err.

Verification
REQ-031 SHALL cover: write frame 1_0000010_10101010 -> wr_stb one cycle, wr_addr=2, regs_flat[23:16]=0xAA, others 0.
REQ-032 SHALL cover: after REQ-031, read frame 0_0000010_xxxxxxxx -> CIPO bits 10101010 on the 8 data-phase SCLK rises, registers unchanged.
REQ-033 SHALL cover: write to addr 5 (NUM_REGS=5) -> frame_err pulse, no wr_stb, regs_flat unchanged; read addr 9 -> CIPO all zeros.
REQ-034 SHALL cover: 15-bit and 17-bit write frames -> frame_err pulse each, no register change.
REQ-035 SHALL cover: rst_n pulsed after 6 SCLK of a write, nCS held low to frame end -> all outputs 0, no commit; next full write commits normally.
REQ-036 SHALL cover: NUM_REGS=16, ADDR_W=4, DATA_W=16 -> 21-bit write to addr 15 data 0xBEEF lands at regs_flat[255:240].
